// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D) requesters.
// Define TIMEOUT_EN to abort an access stalled for TIMEOUT_CYCLES in BUSY.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_ack,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    ACK
  } state_t;

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_DATA_BURST);

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic          gnt_d;
  logic          gnt_i;
  logic          busy;
  logic          tmo;

  // Data wins unless it has used its burst allowance against a waiting fetch.
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if (state == IDLE) begin
      if (d_req && !(i_req && burst_cnt == BMAX)) begin
        gnt_d = 1'b1;
      end else if (i_req) begin
        gnt_i = 1'b1;
      end
    end
  end

  assign busy = (state == BUSY_I) || (state == BUSY_D);

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo = busy && !mem_ack && (tmo_cnt == TLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= tmo;
      if (gnt_d || gnt_i) begin
        tmo_cnt <= '0;
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      rdata     <= '0;
      addr_sel  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_d || gnt_i) begin
            state     <= gnt_d ? BUSY_D : BUSY_I;
            addr_sel  <= gnt_d;
            mem_req   <= 1'b1;
            mem_we    <= gnt_d && d_we;
            mem_addr  <= gnt_d ? d_addr : i_addr;
            mem_wdata <= gnt_d ? d_wdata : '0;
          end
          if (gnt_i || (gnt_d && !i_req)) begin
            burst_cnt <= '0;
          end else if (gnt_d && burst_cnt != BMAX) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack || tmo) begin
            state   <= ACK;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            i_ack   <= (state == BUSY_I);
            d_ack   <= (state == BUSY_D);
            // Stores keep the last read value; an aborted access returns 0.
            if (tmo) begin
              rdata <= '0;
            end else if (!mem_we) begin
              rdata <= mem_rdata;
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized traffic against a timestamp-based transaction model.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        i_ack;
  logic        d_ack;
  logic [31:0] rdata;
  logic        addr_sel;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DATA_BURST(MAXB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req(i_req),
    .i_addr(i_addr),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .i_ack(i_ack),
    .d_ack(d_ack),
    .rdata(rdata),
    .addr_sel(addr_sel),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic quick_load(input logic [31:0] a, input logic [31:0] v);
    d_req = 1'b1; d_we = 1'b0; d_addr = a;
    tick();
    mem_ack = 1'b1; mem_rdata = v;
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    mid();
    nvec++;
    if ({i_ack, d_ack, addr_sel, mem_req, mem_we, err} !== 6'b0) begin
      nerr++;
      $display("FAIL rst_ctl: got %b want 000000",
               {i_ack, d_ack, addr_sel, mem_req, mem_we, err});
    end
    nvec++;
    if (rdata !== 32'h0) begin
      nerr++; $display("FAIL rst_rdata: got %h want 0", rdata);
    end
    nvec++;
    if (mem_addr !== 32'h0) begin
      nerr++; $display("FAIL rst_addr: got %h want 0", mem_addr);
    end
    nvec++;
    if (mem_wdata !== 32'h0) begin
      nerr++; $display("FAIL rst_wdata: got %h want 0", mem_wdata);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0040_0000;
    tick(); mid();
    nvec++;
    if ({mem_req, addr_sel, mem_we} !== 3'b100) begin
      nerr++;
      $display("FAIL fetch_ctl: got %b want 100", {mem_req, addr_sel, mem_we});
    end
    nvec++;
    if (mem_addr !== 32'h0040_0000) begin
      nerr++; $display("FAIL fetch_addr: got %h want 00400000", mem_addr);
    end
    tick(); mid();
    nvec++;
    if ({mem_req, i_ack} !== 2'b10) begin
      nerr++; $display("FAIL fetch_wait: got %b want 10", {mem_req, i_ack});
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    mid();
    tick();
    mem_ack = 1'b0;
    mid();
    nvec++;
    if ({i_ack, d_ack, mem_req} !== 3'b100) begin
      nerr++;
      $display("FAIL fetch_ack: got %b want 100", {i_ack, d_ack, mem_req});
    end
    nvec++;
    if (rdata !== 32'h2008_0005) begin
      nerr++; $display("FAIL fetch_rdata: got %h want 20080005", rdata);
    end
    tick();
    i_req = 1'b0;
    mid();
    nvec++;
    if (i_ack !== 1'b0 || rdata !== 32'h2008_0005) begin
      nerr++;
      $display("FAIL fetch_hold: got ack=%b rdata=%h want ack=0 rdata=20080005",
               i_ack, rdata);
    end
  endtask

  task automatic test_simultaneous();
    tick();
    i_req = 1'b1; i_addr = 32'h0040_0004;
    d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h1001_0000; d_wdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    mid();
    nvec++;
    if ({mem_req, addr_sel, mem_we} !== 3'b111) begin
      nerr++;
      $display("FAIL sim_d_ctl: got %b want 111", {mem_req, addr_sel, mem_we});
    end
    nvec++;
    if (mem_addr !== 32'h1001_0000 || mem_wdata !== 32'hCAFE_F00D) begin
      nerr++;
      $display("FAIL sim_d_bus: got %h/%h want 10010000/cafef00d",
               mem_addr, mem_wdata);
    end
    tick();
    mem_ack = 1'b0; d_req = 1'b0;
    mid();
    nvec++;
    if ({d_ack, i_ack} !== 2'b10) begin
      nerr++; $display("FAIL sim_d_ack: got %b want 10", {d_ack, i_ack});
    end
    nvec++;
    if (rdata !== 32'h2008_0005) begin
      nerr++; $display("FAIL sim_store_rdata: got %h want 20080005", rdata);
    end
    tick(); mid();
    nvec++;
    if ({mem_req, addr_sel} !== 2'b01) begin
      nerr++; $display("FAIL sim_idle: got %b want 01", {mem_req, addr_sel});
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    mid();
    nvec++;
    if ({mem_req, addr_sel, mem_we} !== 3'b100 || mem_addr !== 32'h0040_0004) begin
      nerr++;
      $display("FAIL sim_i_grant: got %b %h want 100 00400004",
               {mem_req, addr_sel, mem_we}, mem_addr);
    end
    tick();
    mem_ack = 1'b0; i_req = 1'b0;
    mid();
    nvec++;
    if (i_ack !== 1'b1 || rdata !== 32'h1111_2222) begin
      nerr++;
      $display("FAIL sim_i_ack: got %b %h want 1 11112222", i_ack, rdata);
    end
  endtask

  task automatic test_burst();
    int  grants = 0;
    int  dacks  = 0;
    int  run    = 0;
    int  dleft  = 12;
    bit  prev   = 1'b0;
    bit  exp_d;
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_addr = 32'h0000_0200;
    mem_ack = 1'b1;
    for (int cyc = 0; cyc < 200 && grants < 15; cyc++) begin
      mem_rdata = $urandom;
      if (dacks == 12) d_req = 1'b0;
      mid();
      if (d_ack === 1'b1) dacks++;
      if (mem_req === 1'b1 && !prev) begin
        exp_d = (dleft > 0) && (run < MAXB);
        nvec++;
        if (addr_sel !== exp_d) begin
          nerr++;
          $display("FAIL burst_grant%0d: got sel=%b want %b", grants, addr_sel, exp_d);
        end
        if (exp_d) begin
          dleft--; run++;
        end else begin
          run = 0;
        end
        grants++;
      end
      prev = mem_req;
      tick();
    end
    nvec++;
    if (grants != 15 || dacks != 12) begin
      nerr++;
      $display("FAIL burst_count: got grants=%0d dacks=%0d want 15/12", grants, dacks);
    end
    clear_inputs();
  endtask

  task automatic test_ack_held();
    do_reset();
    i_req = 1'b1; i_addr = 32'h0000_0800;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    for (int cyc = 0; cyc < 18; cyc++) begin
      mid();
      nvec++;
      if (i_ack !== (cyc % 3 == 2) || mem_req !== (cyc % 3 == 1)) begin
        nerr++;
        $display("FAIL held_cyc%0d: got ack=%b req=%b want %b %b", cyc,
                 i_ack, mem_req, (cyc % 3 == 2), (cyc % 3 == 1));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    tick(); mid();
    nvec++;
    if (mem_req !== 1'b1 || addr_sel !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_busy: got %b%b want 11", mem_req, addr_sel);
    end
    tick();
    #2 reset = 1'b1;
    #1;
    nvec++;
    if ({i_ack, d_ack, addr_sel, mem_req, mem_we, err} !== 6'b0 ||
        mem_addr !== 32'h0 || rdata !== 32'h0) begin
      nerr++;
      $display("FAIL rmid_clear: got %b %h %h want 000000 0 0",
               {i_ack, d_ack, addr_sel, mem_req, mem_we, err}, mem_addr, rdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    reset = 1'b0; d_req = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      mid();
      if (d_ack !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    nvec++;
    if (seen) begin
      nerr++; $display("FAIL rmid_noack: got activity=1 want 0");
    end
  endtask

  task automatic test_timeout();
    int rise  = -1;
    int errat = -1;
    int ackat = -1;
    int nerrp = 0;
    int nreq  = 0;
    logic [31:0] ack_rd = 32'hFFFF_FFFF;
    do_reset();
    quick_load(32'h0000_0500, 32'h5A5A_5A5A);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
    for (int cyc = 0; cyc < 41; cyc++) begin
      mid();
      if (mem_req === 1'b1) nreq++;
      if (mem_req === 1'b1 && rise < 0) rise = cyc;
      if (err === 1'b1) nerrp++;
      if (err === 1'b1 && errat < 0) errat = cyc;
      if (d_ack === 1'b1 && ackat < 0) begin
        ackat = cyc; ack_rd = rdata;
      end
      tick();
      if (ackat >= 0) d_req = 1'b0;
    end
`ifdef TIMEOUT_EN
    nvec++;
    if (rise != 1 || errat != rise + TMO || ackat != errat) begin
      nerr++;
      $display("FAIL tmo_timing: got rise=%0d err=%0d ack=%0d want 1 %0d %0d",
               rise, errat, ackat, 1 + TMO, 1 + TMO);
    end
    nvec++;
    if (ack_rd !== 32'h0 || nerrp != 1 || nreq != TMO) begin
      nerr++;
      $display("FAIL tmo_result: got rd=%h errs=%0d req=%0d want 0 1 %0d",
               ack_rd, nerrp, nreq, TMO);
    end
`else
    nvec++;
    if (rise != 1 || nreq != 40 || ackat != -1) begin
      nerr++;
      $display("FAIL notmo_wait: got rise=%0d req=%0d ack=%0d want 1 40 -1",
               rise, nreq, ackat);
    end
    nvec++;
    if (nerrp != 0 || rdata !== 32'h5A5A_5A5A) begin
      nerr++;
      $display("FAIL notmo_err: got errs=%0d rd=%h want 0 5a5a5a5a", nerrp, rdata);
    end
`endif
    do_reset();
  endtask

  task automatic test_random();
    bit          m_active = 1'b0;
    bit          m_who_d  = 1'b0;
    bit          m_we     = 1'b0;
    bit          m_ack_d  = 1'b0;
    bit          m_sel    = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_rdata  = '0;
    int          m_start  = 0;
    int          m_free   = 0;
    int          m_ack_at = -1;
    int          m_burst  = 0;
    int          lat      = 0;
    bit          seen     = 1'b0;
    bit          exp_req;
    bit          want_d;
    do_reset();
    for (int t = 0; t < 800; t++) begin
      if (i_ack === 1'b1) i_req = 1'b0;
      else if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin
          i_req = 1'b1; i_addr = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) i_req = 1'b0;
      if (d_ack === 1'b1) d_req = 1'b0;
      else if (!d_req) begin
        if ($urandom_range(0, 1) == 0) begin
          d_req = 1'b1; d_we = $urandom_range(0, 1) == 1;
          d_addr = $urandom; d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) d_req = 1'b0;
      if (mem_req === 1'b1) begin
        if (!seen) begin
          seen = 1'b1; lat = $urandom_range(0, 3);
        end
        if (lat == 0) begin
          mem_ack = 1'b1; mem_rdata = $urandom;
        end else begin
          mem_ack = 1'b0; lat--;
        end
      end else begin
        seen = 1'b0;
        mem_ack = $urandom_range(0, 4) == 0;
        mem_rdata = $urandom;
      end
      mid();
      exp_req = m_active && (t >= m_start);
      nvec++;
      if (mem_req !== exp_req) begin
        nerr++; $display("FAIL rnd_req t=%0d: got %b want %b", t, mem_req, exp_req);
      end
      nvec++;
      if (i_ack !== (m_ack_at == t && !m_ack_d) || d_ack !== (m_ack_at == t && m_ack_d)) begin
        nerr++;
        $display("FAIL rnd_ack t=%0d: got i=%b d=%b want i=%b d=%b", t, i_ack, d_ack,
                 (m_ack_at == t && !m_ack_d), (m_ack_at == t && m_ack_d));
      end
      nvec++;
      if (rdata !== m_rdata) begin
        nerr++; $display("FAIL rnd_rdata t=%0d: got %h want %h", t, rdata, m_rdata);
      end
      nvec++;
      if (addr_sel !== m_sel || err !== 1'b0) begin
        nerr++;
        $display("FAIL rnd_sel t=%0d: got sel=%b err=%b want %b 0", t, addr_sel, err, m_sel);
      end
      if (exp_req) begin
        nvec++;
        if (mem_addr !== m_addr || mem_we !== m_we || (m_we && mem_wdata !== m_wdata)) begin
          nerr++;
          $display("FAIL rnd_bus t=%0d: got %h %b %h want %h %b %h", t,
                   mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata);
        end
      end
      if (m_active) begin
        if (t >= m_start && mem_ack) begin
          m_active = 1'b0;
          m_ack_at = t + 1;
          m_ack_d  = m_who_d;
          m_free   = t + 2;
          if (!m_we) m_rdata = mem_rdata;
        end
      end else if (t >= m_free) begin
        want_d = d_req && !(i_req && m_burst == MAXB);
        if (want_d || i_req) begin
          m_active = 1'b1;
          m_start  = t + 1;
          m_who_d  = want_d;
          m_sel    = want_d;
          m_we     = want_d && d_we;
          m_addr   = want_d ? d_addr : i_addr;
          m_wdata  = d_wdata;
          if (want_d && i_req) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
          else m_burst = 0;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_burst();
    test_ack_held();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
